// File: rtl/div32_seq.sv
// div32_seq: radix-2 restoring 32-bit divider, start/busy/done handshake.
// Optional signed support when DIV32_SIGNED_EN is defined.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

`ifdef DIV32_SIGNED_EN
  logic sa, sb;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Magnitudes on capture, sign bookkeeping, signed result correction
  always_comb begin
    sa     = is_signed & dividend[WIDTH-1];
    sb     = is_signed & divisor[WIDTH-1];
    a_abs  = sa ? (~dividend + WIDTH'(1)) : dividend;
    b_abs  = sb ? (~divisor + WIDTH'(1)) : divisor;
    qneg_d = accept ? (sa ^ sb) : qneg_q;
    rneg_d = accept ? sa : rneg_q;
    q_fix  = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix  = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // Sign flags for the operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Unsigned-only build: operands and results pass straight through
  always_comb begin
    a_abs = dividend;
    b_abs = divisor;
    q_fix = quo_q;
    r_fix = rem_q;
  end
`endif

  // Trial subtract, ALU style: add inverted divisor with carry-in 1
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = {1'b0, rem_sh}
              + {1'b0, ~{1'b0, dvsr_q}}
              + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
  end

  // Next-state and datapath update for IDLE/RUN/FIX
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvnd_d  = dividend;
          dvsr_d  = b_abs;
          quo_d   = a_abs;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = no_borrow ? trial[WIDTH-1:0]
                          : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // first FIX cycle registers results, second one presents done
        if (!done_q) begin
          quot_d = dz_q ? '1 : q_fix;
          remo_d = dz_q ? dvnd_q : r_fix;
          dbz_d  = dz_q;
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed vectors for div32_seq.
// Expected values follow DIV32_SIGNED_EN when it is defined.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  div32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // called at E0+#1 (n0 edges already elapsed); returns in done cycle
  task automatic wait_done(input string tag, input int n0,
                           input logic [31:0] eq,
                           input logic [31:0] er,
                           input logic ez);
    int n;
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'd33);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, ez});
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic op(input string tag, input logic sg,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er,
                    input logic ez);
    @(posedge clk); #1;
    start = 1'b1;
    is_signed = sg;
    dividend = a;
    divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    wait_done(tag, 0, eq, er, ez);
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int extra;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    op("u0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    op("umax_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
       32'd1, 32'd0, 1'b0);
    op("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1,
       32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef DIV32_SIGNED_EN
    op("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
       32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
       32'hFFFFFFFD, 32'd1, 1'b0);
    op("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
       32'h80000000, 32'd0, 1'b0);
`else
    op("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
       32'h7FFFFFFC, 32'd1, 1'b0);
    op("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
       32'd0, 32'd7, 1'b0);
    op("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
       32'd0, 32'h80000000, 1'b0);
`endif

    // start pulse while busy must be ignored
    @(posedge clk); #1;
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    is_signed = 1'b1;
    dividend = 32'd5;
    divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    wait_done("hs1", 5, 32'd100, 32'd0, 1'b0);

    // start in done cycle not taken; next cycle it is
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd77;
    divisor = 32'd5;
    @(posedge clk); #1;
    chk("hs.done_cyc_done", {31'd0, done}, 32'd0);
    chk("hs.done_cyc_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs2.busy0", {31'd0, busy}, 32'd1);
    wait_done("hs2", 0, 32'd15, 32'd2, 1'b0);
    @(posedge clk); #1;
    chk("hs2.done_fall", {31'd0, done}, 32'd0);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("hs.no_extra_done", 32'(extra), 32'd0);

    op("sdz", 1'b1, 32'hFFFFFFFB, 32'd0,
       32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);

    // reset in the middle of an operation
    @(posedge clk); #1;
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd1000000;
    divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.done", {31'd0, done}, 32'd0);
    chk("mrst.q", quotient, 32'd0);
    chk("mrst.r", remainder, 32'd0);
    chk("mrst.dz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op("post_rst", 1'b0, 32'd1000000, 32'd3,
       32'd333333, 32'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
